// File: rtl/dds_multi_pkg.sv
// Shared definitions for the multi-channel DDS.
//   dds_mode_e : waveform select codes carried on the mode port and held per channel.
//   ModeW      : width of the mode field.
package dds_multi_pkg;

    localparam int unsigned ModeW = 2;

    typedef enum logic [ModeW-1:0] {
        ModeSaw = 2'b00,
        ModeSqr = 2'b01,
        ModeTri = 2'b10,
        ModeSin = 2'b11
    } dds_mode_e;

endpackage

// File: rtl/dds_multi_sine_lut.sv
// Quarter-wave sine ROM with a registered read (second pipeline stage of the sine path).
//   clk    : system clock
//   rst_n  : synchronous active-low reset, clears the read register
//   en_i   : read register advances only when high (pipeline stall otherwise)
//   addr_i : quarter-wave index, 0 = phase 0, 2^LUT_AW-1 = just below 90 degrees
//   amp_o  : amplitude 0 .. 2^DW-1
// The table is built at elaboration from an integer rational approximation of sin()
// (Bhaskara I form, < 0.2 % error), so no real arithmetic reaches synthesis.
module dds_multi_sine_lut #(
    parameter int unsigned LUT_AW = 6,
    parameter int unsigned DW     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [LUT_AW-1:0] addr_i,
    output logic [DW-1:0]     amp_o
);

    localparam int unsigned N = 2 ** LUT_AW;

    // sin(x) ~= 4x(H-x) / (5H^2/4 - x(H-x)) with H = 2N representing 180 degrees.
    function automatic logic [DW-1:0] sine_val(input int unsigned idx);
        longint unsigned n, x, xr, amax, num, den;
        n    = longint'(N);
        x    = longint'(idx);
        amax = (64'd1 << DW) - 64'd1;
        xr   = x * (64'd2 * n - x);
        num  = 64'd4 * xr * amax;
        den  = 64'd5 * n * n - xr;
        return DW'((64'd2 * num + den) / (64'd2 * den));
    endfunction

    logic [DW-1:0] rom [N];

    for (genvar i = 0; i < N; i++) begin : g_rom
        assign rom[i] = sine_val(i);
    end

    logic [DW-1:0] amp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            amp_q <= '0;
        end else if (en_i) begin
            amp_q <= rom[addr_i];
        end
    end

    assign amp_o = amp_q;

endmodule

// File: rtl/dds_multi.sv
// Multi-channel direct digital synthesiser.
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   en        : advance accumulators and pipeline; hold everything when low
//   set       : one-cycle load strobe for channel ch_sel (accepted regardless of en)
//   ch_sel    : target channel of set
//   m         : tuning word
//   phase_off : phase offset added after the accumulator
//   mode      : 00 saw, 01 square, 10 triangle, 11 sine
//   defer     : 1 = tuning word takes effect at the channel's next wrap
//   sync      : zero all accumulators and drop pending loads
//   out       : channel c sample at [c*OUT_W +: OUT_W], unsigned offset-binary
//   wrap      : one-cycle pulse per channel on accumulator carry-out
// Pipeline: acc -> S1 (p = acc + offset, top bits only) -> S2 (waveform) -> out.
module dds_multi
    import dds_multi_pkg::*;
#(
    parameter int unsigned NCH    = 2,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned LUT_AW = 6,
    localparam int unsigned ChW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 set,
    input  logic [ChW-1:0]       ch_sel,
    input  logic [ACC_W-1:0]     m,
    input  logic [ACC_W-1:0]     phase_off,
    input  logic [ModeW-1:0]     mode,
    input  logic                 defer,
    input  logic                 sync,
    output logic [NCH*OUT_W-1:0] out,
    output logic [NCH-1:0]       wrap
);

    // Only the top phase bits feed the waveforms, so S1 keeps just those.
    localparam int unsigned PW = (OUT_W > LUT_AW + 2) ? OUT_W : LUT_AW + 2;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [ACC_W-1:0]  acc_q, acc_d, tw_q, tw_d;
        logic [ACC_W-1:0]  pend_tw_q, pend_tw_d, off_q, off_d;
        logic              pend_q, pend_d, wrap_q, wrap_d;
        dds_mode_e         mode_q, mode_d;
        logic [ACC_W:0]    sum;
        logic              sel;

        logic [PW-1:0]     p_q, p_d;
        dds_mode_e         mode_s2_q;
        logic              half_q;
        logic [OUT_W-1:0]  wave_q, wave_d, tri_v, p_top;
        logic [OUT_W-2:0]  amp;
        logic [LUT_AW-1:0] lut_idx;

        assign sel = set && (ch_sel == ChW'(c));
        assign sum = {1'b0, acc_q} + {1'b0, tw_q};

        always_comb begin
            acc_d     = acc_q;
            tw_d      = tw_q;
            pend_tw_d = pend_tw_q;
            pend_d    = pend_q;
            off_d     = off_q;
            mode_d    = mode_q;
            wrap_d    = 1'b0;
            if (sync) begin
                acc_d  = '0;
                pend_d = 1'b0;
            end else if (en) begin
                acc_d  = sum[ACC_W-1:0];
                wrap_d = sum[ACC_W];
                // The wrapping addition already used the old word; the new one starts next.
                if (sum[ACC_W] && pend_q) begin
                    tw_d   = pend_tw_q;
                    pend_d = 1'b0;
                end
            end
            // Applied after the wrap handling so a load in the wrap cycle becomes the new
            // pending word (or the live word, if immediate) rather than being consumed.
            if (sel) begin
                mode_d = dds_mode_e'(mode);
                off_d  = phase_off;
                if (defer && !sync) begin
                    pend_tw_d = m;
                    pend_d    = 1'b1;
                end else begin
                    tw_d   = m;
                    pend_d = 1'b0;
                end
            end
        end

        always_comb begin
            p_d   = PW'((acc_q + off_q) >> (ACC_W - PW));
            p_top = p_q[PW-1 -: OUT_W];
            tri_v = {p_top[OUT_W-2:0], 1'b0};
            // Quadrants 1 and 3 read the quarter wave backwards.
            lut_idx = p_q[PW-2] ? ~p_q[PW-3 -: LUT_AW] : p_q[PW-3 -: LUT_AW];
            unique case (mode_q)
                ModeSaw: wave_d = p_top;
                ModeSqr: wave_d = p_q[PW-1] ? {OUT_W{1'b0}} : {OUT_W{1'b1}};
                ModeTri: wave_d = p_q[PW-1] ? ~tri_v : tri_v;
                ModeSin: wave_d = '0;  // sine comes from the LUT register instead
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_q     <= '0;
                tw_q      <= '0;
                pend_tw_q <= '0;
                pend_q    <= 1'b0;
                off_q     <= '0;
                mode_q    <= ModeSaw;
                wrap_q    <= 1'b0;
                p_q       <= '0;
                wave_q    <= '0;
                mode_s2_q <= ModeSaw;
                half_q    <= 1'b0;
            end else begin
                acc_q     <= acc_d;
                tw_q      <= tw_d;
                pend_tw_q <= pend_tw_d;
                pend_q    <= pend_d;
                off_q     <= off_d;
                mode_q    <= mode_d;
                wrap_q    <= wrap_d;
                if (en) begin
                    p_q       <= p_d;
                    wave_q    <= wave_d;
                    mode_s2_q <= mode_q;
                    half_q    <= p_q[PW-1];
                end
            end
        end

        dds_multi_sine_lut #(
            .LUT_AW (LUT_AW),
            .DW     (OUT_W - 1)
        ) u_lut (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (en),
            .addr_i (lut_idx),
            .amp_o  (amp)
        );

        // {1,a} = mid + a; {0,~a} = mid - 1 - a.
        assign out[c*OUT_W +: OUT_W] = (mode_s2_q == ModeSin) ?
                                       {~half_q, (half_q ? ~amp : amp)} : wave_q;
        assign wrap[c] = wrap_q;
    end

endmodule

// File: tb/tb_dds_multi.sv
// Directed self-checking bench for dds_multi (NCH=2, ACC_W=32, OUT_W=8, LUT_AW=6).
module tb_dds_multi;
    import dds_multi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, en, set, defer, sync;
    logic [0:0]  ch_sel;
    logic [31:0] m, phase_off;
    logic [1:0]  mode;
    logic [15:0] out;
    logic [1:0]  wrap;

    int checks = 0;
    int fails  = 0;

    int          last0, last1, n0, n1, exp_v;
    logic [7:0]  prev0, prev1;
    logic [15:0] held;
    logic [7:0]  s0 [0:400];
    logic [7:0]  s1 [0:400];

    always #5 clk = ~clk;

    dds_multi #(
        .NCH    (2),
        .ACC_W  (32),
        .OUT_W  (8),
        .LUT_AW (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .set       (set),
        .ch_sel    (ch_sel),
        .m         (m),
        .phase_off (phase_off),
        .mode      (mode),
        .defer     (defer),
        .sync      (sync),
        .out       (out),
        .wrap      (wrap)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input longint obs, input longint lo,
                               input longint hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; set = 1'b0; sync = 1'b0; defer = 1'b0;
        ch_sel = '0; m = '0; phase_off = '0; mode = ModeSaw;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // One-edge load strobe.
    task automatic load(input int ch, input logic [31:0] mv, input logic [31:0] off,
                        input logic [1:0] md, input logic df);
        set = 1'b1; ch_sel = 1'(ch); m = mv; phase_off = off; mode = md; defer = df;
        step();
        set = 1'b0; defer = 1'b0;
    endtask

    initial begin
        // Reset and saw ramp: edge k after the load edge (k=1) shows (k-3) mod 256.
        do_reset();
        check("reset out", out, 0);
        check("reset wrap", wrap, 0);
        en = 1'b1;
        load(0, 32'h0100_0000, 0, ModeSaw, 1'b0);
        for (int k = 2; k <= 520; k++) begin
            step();
            check($sformatf("saw k=%0d", k), out[7:0], (k >= 3) ? ((k - 3) & 255) : 0);
            check($sformatf("saw wrap k=%0d", k), wrap[0], (k == 257 || k == 513) ? 1 : 0);
        end
        check("idle ch1 out", out[15:8], 0);

        // Audio-rate squares: half periods of 2^31/m cycles.
        do_reset();
        en = 1'b1;
        load(0, 157482, 0, ModeSqr, 1'b0);
        load(1, 314964, 0, ModeSqr, 1'b0);
        last0 = -1; last1 = -1; n0 = 0; n1 = 0;
        for (int i = 1; i <= 30000; i++) begin
            step();
            if (i == 10) begin
                prev0 = out[7:0];
                prev1 = out[15:8];
                check("sq0 first half high", prev0, 255);
                check("sq1 first half high", prev1, 255);
            end else if (i > 10) begin
                if (out[7:0] != prev0) begin
                    if (last0 >= 0) begin
                        check_range("sq0 half period", i - last0, 13635, 13637);
                        n0++;
                    end
                    last0 = i;
                    prev0 = out[7:0];
                end
                if (out[15:8] != prev1) begin
                    if (last1 >= 0) begin
                        check_range("sq1 half period", i - last1, 6817, 6819);
                        n1++;
                    end
                    last1 = i;
                    prev1 = out[15:8];
                end
            end
        end
        check("sq0 half periods seen", n0, 1);
        check("sq1 half periods seen", n1, 3);

        // Deferred retune at acc=0x80000000: step 1 until the wrap (edge 257), then step 2.
        do_reset();
        en = 1'b1;
        load(0, 32'h0100_0000, 0, ModeSaw, 1'b0);
        for (int k = 2; k <= 129; k++) step();
        load(0, 32'h0200_0000, 0, ModeSaw, 1'b1);
        for (int k = 131; k <= 270; k++) begin
            step();
            exp_v = (k <= 259) ? ((k - 3) & 255) : ((2 * (k - 259)) & 255);
            check($sformatf("defer k=%0d", k), out[7:0], exp_v);
        end

        // Immediate retune at the same point: step 2 from the next accumulation.
        do_reset();
        en = 1'b1;
        load(0, 32'h0100_0000, 0, ModeSaw, 1'b0);
        for (int k = 2; k <= 129; k++) step();
        load(0, 32'h0200_0000, 0, ModeSaw, 1'b0);
        for (int k = 131; k <= 140; k++) begin
            step();
            exp_v = (k <= 132) ? (k - 3) : (129 + 2 * (k - 132));
            check($sformatf("immediate k=%0d", k), out[7:0], exp_v);
        end

        // Sine with quarter-period offset on ch1; both start together from en.
        do_reset();
        load(0, 32'h0100_0000, 0, ModeSin, 1'b0);
        load(1, 32'h0100_0000, 32'h4000_0000, ModeSin, 1'b0);
        check("sine stalled out", out, 0);
        en = 1'b1;
        for (int j = 1; j <= 400; j++) begin
            step();
            s0[j] = out[7:0];
            s1[j] = out[15:8];
        end
        check("sine phase 0", s0[2], 128);
        check("sine phase 45deg", s0[34], 218);
        check("sine peak", s0[66], 255);
        check("sine phase 180deg", s0[130], 127);
        check("sine trough", s0[194], 0);
        check("sine phase 360deg", s0[258], 128);
        for (int j = 2; j <= 300; j++) begin
            check($sformatf("ch1 leads by 64 j=%0d", j), s1[j], s0[j + 64]);
        end

        // Hold: en low freezes out and suppresses wrap.
        en = 1'b0;
        held = out;
        for (int i = 0; i < 100; i++) begin
            step();
            check("hold out", out, held);
            check("hold wrap", wrap, 0);
        end

        // sync with a deferred set on ch1: accumulators zeroed, ch1 word applied at once.
        en = 1'b1;
        sync = 1'b1;
        load(1, 32'h0200_0000, 0, ModeSaw, 1'b1);
        sync = 1'b0;
        check("sync wrap", wrap, 0);
        step();
        step();
        check("sync ch0 phase 0", out[7:0], 128);
        check("sync ch1 first", out[15:8], 0);
        step();
        check("sync ch1 step 2a", out[15:8], 2);
        step();
        check("sync ch1 step 2b", out[15:8], 4);

        // Reset with a deferred load pending: it must never surface.
        do_reset();
        en = 1'b1;
        load(0, 32'h0100_0000, 0, ModeSaw, 1'b0);
        for (int k = 2; k <= 10; k++) step();
        load(0, 32'h0400_0000, 0, ModeSaw, 1'b1);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            check("post-reset out", out, 0);
            check("post-reset wrap", wrap, 0);
        end

        // Triangle: rises 2 per step for half a period, then falls from 255.
        load(0, 32'h0100_0000, 0, ModeTri, 1'b0);
        for (int k = 2; k <= 300; k++) begin
            step();
            exp_v = (k >= 3) ? ((k - 3) & 255) : 0;
            exp_v = (exp_v < 128) ? (2 * exp_v) : (255 - 2 * (exp_v - 128));
            check($sformatf("tri k=%0d", k), out[7:0], exp_v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
